// File: rtl/game_event_generator.sv
// ============================================================================
// game_event_generator
// ----------------------------------------------------------------------------
// Purpose: Game-flow controller. It waits in Sidle for a start-key press,
//          runs a game in Splaying while tracking lives and aliens, and parks
//          in Sdone after a win or a loss until the next reset.
//
// Configuration macro:
//   START_DEBOUNCE_EN : when defined, the synchronized start key must stay
//                       high for DEBOUNCE_CYCLES consecutive cycles before its
//                       rising edge is accepted.
//
// Parameters:
//   NUM_LIVES        lives loaded at game start (1..7)
//   NUM_ALIENS       aliens loaded at game start (1..63)
//   DEBOUNCE_CYCLES  start-key stability count (1..65535)
//
// Ports:
//   clk                  in   system clock, rising edge
//   resetN               in   asynchronous active-low reset
//   startKey             in   asynchronous level, high = key pressed
//   alienHitPulse        in   one-cycle pulse, one alien destroyed
//   playerHitPulse       in   one-cycle pulse, player ship hit
//   invadersLandedPulse  in   one-cycle pulse, aliens reached the ground
//   startGamePulse       out  one-cycle pulse, game starts
//   lostGamePulse        out  one-cycle pulse, game lost
//   winGamePulse         out  one-cycle pulse, game won
//   livesLeft[2:0]       out  lives remaining
//   aliensLeft[5:0]      out  aliens remaining
//   gameActive           out  high while in Splaying
// ============================================================================
module game_event_generator #(
    parameter int NUM_LIVES       = 3,
    parameter int NUM_ALIENS      = 24,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startKey,
    input  logic       alienHitPulse,
    input  logic       playerHitPulse,
    input  logic       invadersLandedPulse,
    output logic       startGamePulse,
    output logic       lostGamePulse,
    output logic       winGamePulse,
    output logic [2:0] livesLeft,
    output logic [5:0] aliensLeft,
    output logic       gameActive
);

    localparam logic [2:0] LIVES_INIT  = 3'(NUM_LIVES);
    localparam logic [5:0] ALIENS_INIT = 6'(NUM_ALIENS);

    typedef enum logic [1:0] {
        Sidle    = 2'd0,
        Splaying = 2'd1,
        Sdone    = 2'd2
    } state_t;

    state_t     stateQ;
    state_t     stateNext;
    logic       syncQ1;
    logic       syncQ2;
    logic [1:0] fillQ;
    logic       keyDeb;
    logic       prevKey;
    logic       keyRise;
    logic       lossCond;
    logic       winCond;
    logic       startNext;
    logic       lostNext;
    logic       winNext;
    logic [2:0] livesNext;
    logic [5:0] aliensNext;

    // Two-flop synchronizer for startKey; fillQ marks when syncQ2 holds a real sample.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            syncQ1 <= 1'b0;
            syncQ2 <= 1'b0;
            fillQ  <= 2'b00;
        end else begin
            syncQ1 <= startKey;
            syncQ2 <= syncQ1;
            fillQ  <= {fillQ[0], 1'b1};
        end
    end

`ifdef START_DEBOUNCE_EN
    localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE_CYCLES);
    logic [15:0] debCnt;

    // Count consecutive high synchronized samples, saturating at DEB_MAX.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            debCnt <= 16'd0;
        end else if (!syncQ2) begin
            debCnt <= 16'd0;
        end else if (debCnt != DEB_MAX) begin
            debCnt <= debCnt + 16'd1;
        end else begin
            debCnt <= debCnt;
        end
    end

    assign keyDeb = (debCnt == DEB_MAX);
`else
    // The comparison is constant true for any legal DEBOUNCE_CYCLES.
    assign keyDeb = syncQ2 && (DEBOUNCE_CYCLES > 0);
`endif

    // Edge-detect history. It starts at 1 so a key held through reset does
    // not start a game; it is cleared only by a genuine low sample (after the
    // synchronizer has filled) and set again once the debounced key is high.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prevKey <= 1'b1;
        end else if (!fillQ[1]) begin
            prevKey <= prevKey;
        end else if (!syncQ2) begin
            prevKey <= 1'b0;
        end else begin
            prevKey <= prevKey | keyDeb;
        end
    end

    assign keyRise = keyDeb & ~prevKey;

    // Next-state, counter and pulse logic.
    always_comb begin
        stateNext  = stateQ;
        livesNext  = livesLeft;
        aliensNext = aliensLeft;
        startNext  = 1'b0;
        lostNext   = 1'b0;
        winNext    = 1'b0;
        lossCond   = 1'b0;
        winCond    = 1'b0;
        case (stateQ)
            Sidle: begin
                if (keyRise) begin
                    startNext  = 1'b1;
                    livesNext  = LIVES_INIT;
                    aliensNext = ALIENS_INIT;
                    stateNext  = Splaying;
                end else begin
                    stateNext  = Sidle;
                end
            end
            Splaying: begin
                lossCond = invadersLandedPulse | (playerHitPulse & (livesLeft == 3'd1));
                winCond  = alienHitPulse & (aliensLeft == 6'd1) & ~lossCond;
                if (playerHitPulse && (livesLeft != 3'd0)) begin
                    livesNext = livesLeft - 3'd1;
                end else begin
                    livesNext = livesLeft;
                end
                if (alienHitPulse && (aliensLeft != 6'd0)) begin
                    aliensNext = aliensLeft - 6'd1;
                end else begin
                    aliensNext = aliensLeft;
                end
                // Loss is checked first so it wins over a simultaneous win.
                if (lossCond) begin
                    lostNext  = 1'b1;
                    stateNext = Sdone;
                end else if (winCond) begin
                    winNext   = 1'b1;
                    stateNext = Sdone;
                end else begin
                    stateNext = Splaying;
                end
            end
            Sdone: begin
                stateNext = Sdone;
            end
            default: begin
                stateNext = Sidle;
            end
        endcase
    end

    // Registered state, counters and output pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ         <= Sidle;
            livesLeft      <= LIVES_INIT;
            aliensLeft     <= ALIENS_INIT;
            startGamePulse <= 1'b0;
            lostGamePulse  <= 1'b0;
            winGamePulse   <= 1'b0;
            gameActive     <= 1'b0;
        end else begin
            stateQ         <= stateNext;
            livesLeft      <= livesNext;
            aliensLeft     <= aliensNext;
            startGamePulse <= startNext;
            lostGamePulse  <= lostNext;
            winGamePulse   <= winNext;
            gameActive     <= (stateNext == Splaying);
        end
    end

endmodule

// File: tb/tb_game_event_generator.sv
// ============================================================================
// tb_game_event_generator
// ----------------------------------------------------------------------------
// Scoreboard bench: the driver applies one cycle of stimulus, a behavioural
// game model predicts the outputs after that clock edge and queues them; a
// monitor on the falling edge pops each prediction and compares.
// ============================================================================
module tb_game_event_generator;

    localparam int NL  = 3;
    localparam int NA  = 24;
    localparam int DEB = 16;
`ifdef START_DEBOUNCE_EN
    localparam int LAG  = 3;
    localparam int DLEN = DEB;
`else
    localparam int LAG  = 2;
    localparam int DLEN = 1;
`endif

    logic       clk;
    logic       resetN;
    logic       startKey;
    logic       alienHitPulse;
    logic       playerHitPulse;
    logic       invadersLandedPulse;
    logic       startGamePulse;
    logic       lostGamePulse;
    logic       winGamePulse;
    logic [2:0] livesLeft;
    logic [5:0] aliensLeft;
    logic       gameActive;

    game_event_generator #(
        .NUM_LIVES      (NL),
        .NUM_ALIENS     (NA),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk                (clk),
        .resetN             (resetN),
        .startKey           (startKey),
        .alienHitPulse      (alienHitPulse),
        .playerHitPulse     (playerHitPulse),
        .invadersLandedPulse(invadersLandedPulse),
        .startGamePulse     (startGamePulse),
        .lostGamePulse      (lostGamePulse),
        .winGamePulse       (winGamePulse),
        .livesLeft          (livesLeft),
        .aliensLeft         (aliensLeft),
        .gameActive         (gameActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       lost;
        logic       win;
        logic       active;
        logic [2:0] lives;
        logic [5:0] aliens;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   passes = 0;

    // Game model: 0 = waiting for start, 1 = playing, 2 = finished.
    int   mState;
    int   mLives;
    int   mAliens;
    int   tCyc;
    bit   kHist[$];
    bit   curKey;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // A start is accepted at edge t when the key sample taken LAG edges
    // earlier ends a run of exactly DLEN high samples that began after a low
    // sample seen since reset.
    function automatic bit startAccepted(input int t);
        int idx;
        int run;
        int j;
        idx = t - LAG;
        if (idx < 1) return 1'b0;
        run = 0;
        j = idx - 1;
        while (j >= 0 && kHist[j]) begin
            run++;
            j--;
        end
        return (run == DLEN) && ((idx - DLEN) >= 1);
    endfunction

    task automatic step(input bit key, input bit aHit, input bit pHit, input bit land);
        exp_t e;
        bit   loss;
        bit   win;
        startKey            = key;
        alienHitPulse       = aHit;
        playerHitPulse      = pHit;
        invadersLandedPulse = land;
        curKey              = key;
        tCyc++;
        kHist.push_back(key);
        e = '0;
        if (mState == 0) begin
            if (startAccepted(tCyc)) begin
                e.start = 1'b1;
                mLives  = NL;
                mAliens = NA;
                mState  = 1;
            end
        end else if (mState == 1) begin
            loss = land || (pHit && mLives == 1);
            win  = aHit && mAliens == 1 && !loss;
            if (pHit && mLives > 0) mLives--;
            if (aHit && mAliens > 0) mAliens--;
            if (loss) begin
                e.lost = 1'b1;
                mState = 2;
            end else if (win) begin
                e.win  = 1'b1;
                mState = 2;
            end
        end
        e.active = (mState == 1);
        e.lives  = 3'(mLives);
        e.aliens = 6'(mAliens);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(curKey, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic startGame();
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (DLEN + LAG + 1) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset (after any pending prediction has been consumed), check
    // the reset values, then release between clock edges.
    task automatic doReset(input bit keyDuring);
        #5;
        resetN              = 1'b0;
        startKey            = keyDuring;
        alienHitPulse       = 1'b0;
        playerHitPulse      = 1'b0;
        invadersLandedPulse = 1'b0;
        curKey              = keyDuring;
        #1;
        check("rst_pulses", {startGamePulse, lostGamePulse, winGamePulse}, 0);
        check("rst_active", gameActive, 0);
        check("rst_lives", livesLeft, NL);
        check("rst_aliens", aliensLeft, NA);
        sbQ.delete();
        kHist.delete();
        mState  = 0;
        mLives  = NL;
        mAliens = NA;
        tCyc    = 0;
        @(negedge clk);
        #1;
        resetN = 1'b1;
    endtask

    // Monitor: compare every predicted cycle against the DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        if (resetN && sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check("pulses{start,lost,win}", {startGamePulse, lostGamePulse, winGamePulse},
                  {e.start, e.lost, e.win});
            check("gameActive", gameActive, e.active);
            check("livesLeft", livesLeft, e.lives);
            check("aliensLeft", aliensLeft, e.aliens);
        end
    end

    initial begin
        resetN              = 1'b0;
        startKey            = 1'b0;
        alienHitPulse       = 1'b0;
        playerHitPulse      = 1'b0;
        invadersLandedPulse = 1'b0;
        curKey              = 1'b0;
        mState = 0; mLives = NL; mAliens = NA; tCyc = 0;

        // Start from idle, then win by destroying every alien.
        doReset(1'b0);
        startGame();
        repeat (NA) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(3);

        // Lose all lives; later hits and key toggles must do nothing.
        doReset(1'b0);
        startGame();
        repeat (NL) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        repeat (10) step(1'($urandom % 2), 1'b1, 1'b1, 1'($urandom % 2));

        // Last life and last alien hit together: loss wins.
        doReset(1'b0);
        startGame();
        repeat (NA - 1) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (NL - 1) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Key held through reset: no start until released and pressed again.
        doReset(1'b1);
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (DLEN + LAG + 1) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Short glitch followed by a long press.
        doReset(1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Invaders landing ends the game immediately.
        doReset(1'b0);
        startGame();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Reset mid-game with five aliens left.
        doReset(1'b0);
        startGame();
        repeat (NA - 5) step(1'b1, 1'b1, 1'b0, 1'b0);
        doReset(1'b0);
        idle(2);

        // Randomized games.
        for (int g = 0; g < 12; g++) begin
            doReset(1'($urandom % 2));
            for (int c = 0; c < 150; c++) begin
                bit k;
                k = curKey;
                if ($urandom % 8 == 0) k = ~k;
                step(k, 1'($urandom % 100 < 30), 1'($urandom % 100 < 5),
                     1'($urandom % 100 < 2));
            end
        end

        #10;
        check("scoreboard_drained", sbQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
